// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx; master = stimulus side, slave = transmitter.
`timescale 1ns/1ps
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4
);
    localparam int LW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pat_in;
    logic [LW-1:0]    pat_len;
    logic [7:0]       rep_cnt;
    logic             start_valid;
    logic             start_ready;
    logic             abort;
    logic             tx_bit;
    logic             tx_en;
    logic             busy;
    logic             done;

    modport master (
        output pat_in, pat_len, rep_cnt, start_valid, abort,
        input  start_ready, tx_bit, tx_en, busy, done
    );

    modport slave (
        input  pat_in, pat_len, rep_cnt, start_valid, abort,
        output start_ready, tx_bit, tx_en, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial MSB-first pattern transmitter with repeat count and optional inter-repetition gap; all outputs registered.
// Build option: define PARITY_EN to append an even-parity bit after each repetition.
`timescale 1ns/1ps
module seq_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int GAP_CYC = 0
) (
    input  logic            clk,
    input  logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int LW = $clog2(PAT_W + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [7:0]       rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             par_q, par_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;

    logic [LW-1:0]    len_in;
    logic [PAT_W-1:0] cur_sh, nxt_sh;
    logic             rep_end;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        par_d   = par_q;
        done_d  = 1'b0;
        rep_end = 1'b0;
        cur_sh  = pat_q >> idx_q;
        len_in  = ((bus.pat_len == '0) || (bus.pat_len > LW'(PAT_W))) ? LW'(PAT_W) : bus.pat_len;

        case (state_q)
            IDLE: begin
                if (bus.start_valid && !bus.abort) begin
                    state_d = SHIFT;
                    pat_d   = bus.pat_in;
                    len_d   = len_in;
                    idx_d   = len_in - LW'(1);
                    rep_d   = (bus.rep_cnt == 8'd0) ? 8'd1 : bus.rep_cnt;
                    par_d   = 1'b0;
                end
            end
            SHIFT: begin
                // Parity accumulates the bit currently on the line.
                par_d = par_q ^ cur_sh[0];
                if (idx_q != '0) begin
                    idx_d = idx_q - LW'(1);
                end else begin
`ifdef PARITY_EN
                    state_d = PAR;
`else
                    rep_end = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: rep_end = 1'b1;
`endif
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = SHIFT;
                    idx_d   = len_q - LW'(1);
                    par_d   = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rep_end) begin
            if (rep_q > 8'd1) begin
                rep_d = rep_q - 8'd1;
                if (GAP_CYC > 0) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else begin
                    state_d = SHIFT;
                    idx_d   = len_q - LW'(1);
                    par_d   = 1'b0;
                end
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        nxt_sh   = pat_d >> idx_d;
        tx_en_d  = (state_d == SHIFT);
        tx_bit_d = (state_d == SHIFT) ? nxt_sh[0] : 1'b0;
`ifdef PARITY_EN
        if (state_d == PAR) begin
            tx_en_d  = 1'b1;
            tx_bit_d = par_d;
        end
`endif
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            par_q    <= 1'b0;
            tx_bit_q <= 1'b0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            par_q    <= par_d;
            tx_bit_q <= tx_bit_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.tx_bit      = tx_bit_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.start_ready = rdy_q;
endmodule
